// File: rtl/branch_update_queue.sv
// Branch resolution queue: detects mispredicts at execute, pulses a one-cycle
// fetch redirect, and buffers taken-branch corrections for the BTB write port.
module branch_update_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [ADDR_WIDTH-1:0] res_pc,
    input  logic [ADDR_WIDTH-1:0] res_target,
    input  logic                  res_is_jump,
    input  logic                  res_taken,
    input  logic                  res_pred_hit,
    input  logic [ADDR_WIDTH-1:0] res_pred_target,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  is_branch_out,
    output logic                  is_jump_out,
    output logic [ADDR_WIDTH-1:0] inst_pc_out,
    output logic [ADDR_WIDTH-1:0] target_out,
    input  logic                  upd_ready
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem_d  [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem_d [DEPTH];
    logic [DEPTH-1:0]      jmp_mem_q;
    logic [DEPTH-1:0]      jmp_mem_d;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d;

    logic accept;
    logic actual_taken;
    logic mispredict;
    logic enq;
    logic deq;
    logic not_empty;

    // Valid/ready: a resolution transfers on a cycle where res_valid and
    // res_ready are both high; a BTB update transfers where is_branch_out and
    // upd_ready are both high. res_ready depends only on registered count.
    always_comb begin
        not_empty    = (count_q != '0);
        res_ready    = (count_q != FULL_CNT);
        accept       = res_valid & res_ready;
        actual_taken = res_is_jump | res_taken;
        mispredict   = (res_pred_hit != actual_taken)
                     | (actual_taken & res_pred_hit & (res_pred_target != res_target));
        enq          = accept & actual_taken
                     & (~res_pred_hit | (res_pred_target != res_target));
        deq          = not_empty & upd_ready;
    end

    always_comb begin
        pc_mem_d  = pc_mem_q;
        tgt_mem_d = tgt_mem_q;
        jmp_mem_d = jmp_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq) begin
            pc_mem_d[wr_ptr_q]  = res_pc;
            tgt_mem_d[wr_ptr_q] = res_target;
            jmp_mem_d[wr_ptr_q] = res_is_jump;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Redirect to the target when the branch went, else to the fall-through.
    always_comb begin
        flush_d    = 1'b0;
        flush_pc_d = '0;
        if (accept & mispredict) begin
            flush_d    = 1'b1;
            flush_pc_d = actual_taken ? res_target : (res_pc + ADDR_WIDTH'(4));
        end
    end

    always_comb begin
        flush         = flush_q;
        flush_pc      = flush_pc_q;
        is_branch_out = not_empty;
        is_jump_out   = not_empty ? jmp_mem_q[rd_ptr_q] : 1'b0;
        inst_pc_out   = not_empty ? pc_mem_q[rd_ptr_q]  : '0;
        target_out    = not_empty ? tgt_mem_q[rd_ptr_q] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Storage needs no reset: every head output is masked while empty.
    always_ff @(posedge clk) begin
        pc_mem_q  <= pc_mem_d;
        tgt_mem_q <= tgt_mem_d;
        jmp_mem_q <= jmp_mem_d;
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: vector table, multi-cycle corner sequences
// and a random phase, all checked against a queue of expected BTB updates.
module tb_branch_update_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int W     = 2 * AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [AW-1:0] res_pc = '0;
    logic [AW-1:0] res_target = '0;
    logic          res_is_jump = 1'b0;
    logic          res_taken = 1'b0;
    logic          res_pred_hit = 1'b0;
    logic [AW-1:0] res_pred_target = '0;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          is_branch_out;
    logic          is_jump_out;
    logic [AW-1:0] inst_pc_out;
    logic [AW-1:0] target_out;
    logic          upd_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Expected BTB updates, oldest first: {is_jump, pc, target}.
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          valid;
        logic [AW-1:0] pc;
        logic [AW-1:0] target;
        logic          jump;
        logic          taken;
        logic          hit;
        logic [AW-1:0] ptgt;
        logic          upd;
        logic          ef;
        logic [AW-1:0] efpc;
        logic          eenq;
    } vec_t;

    vec_t vecs[9];

    branch_update_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_target(res_target),
        .res_is_jump(res_is_jump), .res_taken(res_taken),
        .res_pred_hit(res_pred_hit), .res_pred_target(res_pred_target),
        .flush(flush), .flush_pc(flush_pc),
        .is_branch_out(is_branch_out), .is_jump_out(is_jump_out),
        .inst_pc_out(inst_pc_out), .target_out(target_out),
        .upd_ready(upd_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                         input logic j, input logic t, input logic h,
                         input logic [AW-1:0] ptgt, input logic upd);
        res_valid       = v;
        res_pc          = pc;
        res_target      = tgt;
        res_is_jump     = j;
        res_taken       = t;
        res_pred_hit    = h;
        res_pred_target = ptgt;
        upd_ready       = upd;
    endtask

    // Independent reference for random stimulus.
    task automatic model(output logic ef, output logic [AW-1:0] efpc, output logic eenq);
        logic at;
        at   = res_is_jump | res_taken;
        ef   = (res_pred_hit != at) || (at && res_pred_hit && res_pred_target != res_target);
        efpc = at ? res_target : res_pc + 32'd4;
        eenq = at && (!res_pred_hit || res_pred_target != res_target);
    endtask

    // Entered #1 after a rising edge with inputs driven; leaves #1 after the next.
    task automatic run_cycle(input logic ef, input logic [AW-1:0] efpc, input logic eenq);
        logic acc;
        logic [W-1:0] head;
        #3;
        chk("res_ready", 64'(res_ready), 64'(exp_q.size() < DEPTH));
        chk("is_branch_out", 64'(is_branch_out), 64'(exp_q.size() != 0));
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("is_jump_out", 64'(is_jump_out), 64'(head[W-1]));
        chk("inst_pc_out", 64'(inst_pc_out), 64'(head[2*AW-1:AW]));
        chk("target_out", 64'(target_out), 64'(head[AW-1:0]));
        acc = res_valid && (exp_q.size() < DEPTH);
        if (upd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc && eenq) exp_q.push_back({res_is_jump, res_pc, res_target});
        @(posedge clk);
        #1;
        chk("flush", 64'(flush), 64'(acc && ef));
        chk("flush_pc", 64'(flush_pc), (acc && ef) ? 64'(efpc) : 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        while (exp_q.size() != 0 && n < 10) begin
            run_cycle(1'b0, '0, 1'b0);
            n++;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic ef, eenq;
        logic [AW-1:0] efpc;

        vecs[0] = '{1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1};
        vecs[1] = '{1'b1, 32'h300, 32'h999, 1'b0, 1'b0, 1'b1, 32'h1234, 1'b0, 1'b1, 32'h304, 1'b0};
        vecs[2] = '{1'b1, 32'h380, 32'h400, 1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{1'b1, 32'h390, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0};
        vecs[4] = '{1'b1, 32'h500, 32'h700, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 1'b1, 32'h700, 1'b1};
        vecs[5] = '{1'b1, 32'h800, 32'h900, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900, 1'b1};
        vecs[6] = '{1'b0, 32'hC00, 32'hD00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h0, 1'b0};
        vecs[8] = '{1'b1, 32'hA00, 32'hB00, 1'b0, 1'b1, 1'b1, 32'hB00, 1'b0, 1'b0, 32'h0, 1'b0};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_flush_pc", 64'(flush_pc), 64'd0);
        chk("rst_is_branch_out", 64'(is_branch_out), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_res_ready", 64'(res_ready), 64'd1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].valid, vecs[i].pc, vecs[i].target, vecs[i].jump, vecs[i].taken,
                  vecs[i].hit, vecs[i].ptgt, vecs[i].upd);
            run_cycle(vecs[i].ef, vecs[i].efpc, vecs[i].eenq);
        end
        drain();

        // Fill to DEPTH, reject while full (also with a pop that cycle), then drain
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), i[0], 1'b1, 1'b0, '0, 1'b0);
            run_cycle(1'b1, 32'h2000 + 32'(i * 16), 1'b1);
        end
        chk("full_res_ready", 64'(res_ready), 64'd0);
        drive(1'b1, 32'h1F00, 32'h2F00, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        run_cycle(1'b1, 32'h2F00, 1'b1);
        run_cycle(1'b1, 32'h2F00, 1'b1);
        upd_ready = 1'b1;
        run_cycle(1'b1, 32'h2F00, 1'b1);
        chk("after_pop_res_ready", 64'(res_ready), 64'd1);
        drain();

        // Wrong-target entry, then simultaneous push and pop at count 1
        drive(1'b1, 32'h500, 32'h700, 1'b0, 1'b1, 1'b1, 32'h600, 1'b0);
        run_cycle(1'b1, 32'h700, 1'b1);
        drive(1'b1, 32'h540, 32'h740, 1'b0, 1'b1, 1'b1, 32'h640, 1'b1);
        run_cycle(1'b1, 32'h740, 1'b1);
        chk("simul_count_one", 64'(exp_q.size()), 64'd1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        run_cycle(1'b0, '0, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255)) << 2,
                  $urandom_range(0, 1) ? 32'h4000 : 32'h8000, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? 32'h4000 : 32'h8000, 1'($urandom_range(0, 2) == 0));
            model(ef, efpc, eenq);
            run_cycle(ef, efpc, eenq);
        end
        drain();

        // Async reset with three entries and a flush pending
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3000 + 32'(i * 8), 32'h6000 + 32'(i * 8), 1'b1, 1'b0, 1'b0, '0, 1'b0);
            run_cycle(1'b1, 32'h6000 + 32'(i * 8), 1'b1);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_flush", 64'(flush), 64'd0);
        chk("arst_flush_pc", 64'(flush_pc), 64'd0);
        chk("arst_is_branch_out", 64'(is_branch_out), 64'd0);
        chk("arst_inst_pc_out", 64'(inst_pc_out), 64'd0);
        chk("arst_target_out", 64'(target_out), 64'd0);
        chk("arst_is_jump_out", 64'(is_jump_out), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_is_branch_out", 64'(is_branch_out), 64'd0);
        chk("post_rst_res_ready", 64'(res_ready), 64'd1);
        chk("post_rst_flush", 64'(flush), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
